output_arbiter: RTL and testbench
=================================

# output_arbiter

Output-side counterpart of the input router in the minimal NoC. The block takes flits from the four per-direction VC buffers filled by route calculation and selects one VC at a time with round-robin arbitration. It holds the grant for a whole packet (wormhole lock from head to tail) and drives a single registered 8-bit output link. Credit-based flow control toward the downstream buffer ensures no flit is sent without space.

## Interface
Parameters:
- NUM_VC, 4, number of VC buffer inputs; fixed at 4 for this NoC, one per direction.
- FLIT_W, 8, flit width.
- CREDITS, 4, downstream buffer depth. This is the initial and maximum credit count.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- vc_flit  input  NUM_VC*FLIT_W  front flit of each VC buffer; VC i occupies bits [i*FLIT_W +: FLIT_W].
- vc_valid  input  NUM_VC  VC i has a flit at its front.
- vc_pop  output  NUM_VC  combinational; one-hot or zero; VC i's front flit is consumed this cycle.
- out_flit  output  FLIT_W  registered flit on the output link.
- out_valid  output  1  registered; out_flit is valid this cycle.
- credit_in  input  1  one-cycle pulse; downstream has freed one slot.
- credit_err  output  1  sticky; credit_in arrived while the counter was already at CREDITS.

## Operation
- Flit type field is flit[7:6]:
  - 01 = head
  - 00 = body
  - 10 = tail
  - 11 = head+tail (single-flit packet)
- flit[5:0] is payload and is never inspected.
- State machine:
  - IDLE: no owner.
  - LOCKED: owner register holds the granted VC index (2 bits).
- Round-robin pointer rr_ptr (2 bits) gives the highest-priority VC. Search order is rr_ptr, rr_ptr+1, … mod NUM_VC.
- Send condition: credit_cnt != 0. The credit_in pulse of the same cycle does not count toward it.
- IDLE, send condition true, at least one vc_valid set:
  - Pick the first valid VC in round-robin order and assert its vc_pop.
  - Its front flit is treated as a head regardless of type.
  - If the type is head+tail or tail: stay IDLE and set rr_ptr = granted+1.
  - Otherwise: go to LOCKED with owner = granted.
- IDLE, send condition false or no valid VC: no pop, no state change.
- LOCKED:
  - vc_pop[owner] = vc_valid[owner] && credit_cnt != 0. All other pops are 0, even if the owner is empty (bubble) and others are valid.
  - A popped flit of type tail or head+tail returns the block to IDLE and sets rr_ptr = owner+1 (mod 4).
- Every pop loads that flit into out_flit and sets out_valid = 1 on the next edge. A cycle without a pop sets out_valid = 0; out_flit holds its last value.
- credit_cnt, width clog2(CREDITS+1):
  - pop only: decrement.
  - credit_in only: increment.
  - both: unchanged.
  - credit_in at CREDITS without a pop: counter stays at CREDITS and credit_err is set (sticky until reset).
- Reset values: state IDLE, owner 0, rr_ptr 0, credit_cnt = CREDITS, out_valid 0, out_flit 0, credit_err 0. vc_pop is 0 while reset is high.
- Reset mid-packet drops the lock immediately. No partial-packet recovery is performed.

## Timing
- Pop to out_valid: 1 cycle. Sustained throughput is 1 flit/cycle while credits last.
- Arbitration and head transfer happen in the same cycle. There is no grant-only cycle.
- Back-to-back packets from different VCs: a tail popped in cycle N allows a new head pop in cycle N+1.
- A single-flit packet in IDLE: the next packet can start the following cycle from rr_ptr = granted+1.
- With credit_cnt = 0 and credit_in high in cycle N: no pop in N; a pop is possible in N+1.
- The critical path runs vc_valid → round-robin search → vc_pop. This path is combinational and feeds the upstream buffer read.

## Test plan
- Reset, then VC2 presents head 0x41, body 0x05, tail 0x86 back-to-back, with credits 4 → vc_pop[2] for 3 cycles, out_flit 0x41, 0x05, 0x86 each one cycle later, credit_cnt = 1, rr_ptr = 3, state IDLE.
- All four VCs valid with single-flit packets 0xC0|i → grant order 0, 1, 2, 3, 0, returning credits each cycle so count never hits 0.
- VC0 locked mid-packet with vc_valid[0] dropped for 2 cycles while VC1 is valid → no pop on VC1; out_valid = 0 for those cycles; VC0 resumes and its tail releases the lock.
- CREDITS = 4, no credit_in, VC1 streams a 6-flit packet → 4 pops, then stall; one credit_in → exactly one further pop the following cycle; simultaneous pop and credit_in leaves the count unchanged.
- credit_in pulsed with credit_cnt = 4 and no pop → credit_err = 1 and stays 1; count stays 4.
- Reset asserted while locked on VC3 → next cycle state IDLE, rr_ptr 0, credit_cnt 4, out_valid 0; a valid VC0 head is granted first after release.

Source files
------------

// File: rtl/output_arbiter.sv
// output_arbiter: round-robin wormhole arbiter over NUM_VC buffers onto one registered link,
// with credit-based flow control toward the downstream buffer.
module output_arbiter #(
    parameter int NUM_VC  = 4,
    parameter int FLIT_W  = 8,
    parameter int CREDITS = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_VC*FLIT_W-1:0]   vc_flit,
    input  logic [NUM_VC-1:0]          vc_valid,
    output logic [NUM_VC-1:0]          vc_pop,
    output logic [FLIT_W-1:0]          out_flit,
    output logic                       out_valid,
    input  logic                       credit_in,
    output logic                       credit_err
);
    localparam int IW = $clog2(NUM_VC);
    localparam int CW = $clog2(CREDITS + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   owner, owner_nxt, rr_ptr, rr_nxt;
    logic [IW-1:0]   pick, sel;
    logic            pick_ok, popping, last;
    logic [CW-1:0]   credit_cnt;
    logic [FLIT_W-1:0] sel_flit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_nxt;
        end
    end

    // descending scan so the lowest offset from rr_ptr wins
    always_comb begin
        pick    = rr_ptr;
        pick_ok = 1'b0;
        for (int i = NUM_VC - 1; i >= 0; i--)
            if (vc_valid[rr_ptr + IW'(i)]) begin
                pick    = rr_ptr + IW'(i);
                pick_ok = 1'b1;
            end
        sel       = (state == LOCKED) ? owner : pick;
        popping   = !reset && credit_cnt != '0 && ((state == LOCKED) ? vc_valid[owner] : pick_ok);
        sel_flit  = vc_flit[sel*FLIT_W +: FLIT_W];
        last      = sel_flit[FLIT_W-1];
        state_nxt = popping ? (last ? IDLE : LOCKED) : state;
        owner_nxt = (popping && !last) ? sel : owner;
        rr_nxt    = (popping && last) ? sel + IW'(1) : rr_ptr;
    end

    always_comb begin
        vc_pop = popping ? NUM_VC'(1'b1) << sel : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            credit_cnt <= CW'(CREDITS);
            credit_err <= 1'b0;
            out_valid  <= 1'b0;
            out_flit   <= '0;
        end else begin
            out_valid <= popping;
            if (popping)
                out_flit <= sel_flit;
            if (popping && !credit_in)
                credit_cnt <= credit_cnt - CW'(1);
            else if (credit_in && !popping) begin
                if (credit_cnt == CW'(CREDITS))
                    credit_err <= 1'b1;
                else
                    credit_cnt <= credit_cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_output_arbiter.sv
// tb_output_arbiter: directed scenarios plus random traffic checked against a packet-level model.
module tb_output_arbiter;
    localparam int CREDITS = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] vc_flit;
    logic [3:0]  vc_valid;
    logic [3:0]  vc_pop;
    logic [7:0]  out_flit;
    logic        out_valid;
    logic        credit_in;
    logic        credit_err;

    output_arbiter #(.NUM_VC(4), .FLIT_W(8), .CREDITS(CREDITS)) dut (
        .clk(clk), .reset(reset), .vc_flit(vc_flit), .vc_valid(vc_valid), .vc_pop(vc_pop),
        .out_flit(out_flit), .out_valid(out_valid), .credit_in(credit_in), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] q[4][$];
    int         credits, owner, rr;
    bit         m_err, m_ov;
    logic [7:0] m_flit;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        credits = CREDITS;
        owner   = -1;
        rr      = 0;
        m_err   = 0;
        m_ov    = 0;
        m_flit  = 8'h00;
        for (int i = 0; i < 4; i++) q[i].delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        vc_valid  = 4'hF;
        vc_flit   = 32'h41414141;
        credit_in = 1'b0;
        #1 check("pop_in_reset", vc_pop, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_flit", out_flit, 0);
        check("rst_credit_err", credit_err, 0);
    endtask

    task automatic step(input logic [3:0] gate, input logic cr);
        int win;
        logic [7:0] f;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            vc_valid[i]        = gate[i] && q[i].size() > 0;
            vc_flit[i*8 +: 8]  = q[i].size() > 0 ? q[i][0] : 8'h00;
        end
        credit_in = cr;
        #1;
        win = -1;
        if (credits > 0) begin
            if (owner >= 0)
                win = vc_valid[owner] ? owner : -1;
            else
                for (int k = 3; k >= 0; k--)
                    if (vc_valid[(rr + k) % 4]) win = (rr + k) % 4;
        end
        check("vc_pop", vc_pop, win < 0 ? 0 : (1 << win));
        m_ov = win >= 0;
        if (win >= 0) begin
            f = q[win].pop_front();
            m_flit = f;
            if (f[7]) begin
                owner = -1;
                rr = (win + 1) % 4;
            end else
                owner = win;
        end
        if (cr && win < 0 && credits == CREDITS) m_err = 1;
        else credits = credits + int'(cr) - int'(win >= 0);
        @(posedge clk);
        #1;
        check("out_valid", out_valid, m_ov);
        check("out_flit", out_flit, m_flit);
        check("credit_err", credit_err, m_err);
    endtask

    task automatic add_packet(input int v, input int len);
        if (len == 1) q[v].push_back(8'hC0 | 8'($urandom_range(63)));
        else begin
            q[v].push_back(8'h40 | 8'($urandom_range(63)));
            for (int j = 0; j < len - 2; j++) q[v].push_back(8'($urandom_range(63)));
            q[v].push_back(8'h80 | 8'($urandom_range(63)));
        end
    endtask

    initial begin
        reset = 1'b1; vc_valid = '0; vc_flit = '0; credit_in = 1'b0;
        model_reset();
        do_reset();
        // VC2 three-flit packet; count ends at 1, then a VC3 head must win from rr_ptr=3
        q[2] = '{8'h41, 8'h05, 8'h86};
        repeat (3) step(4'b0100, 1'b0);
        q[0] = '{8'hC1}; q[3] = '{8'hC3};
        step(4'b1001, 1'b0);
        step(4'b1001, 1'b0);
        // four single-flit packets, round-robin with credits returned every cycle
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q[i].push_back(8'hC0 | 8'(i));
            q[i].push_back(8'hC4 | 8'(i));
        end
        repeat (6) step(4'hF, 1'b1);
        // owner bubble: VC1 must wait while VC0 is locked but empty
        do_reset();
        q[0] = '{8'h41, 8'h05, 8'h86}; q[1] = '{8'hC1};
        step(4'hF, 1'b0);
        repeat (2) step(4'b1110, 1'b0);
        repeat (3) step(4'hF, 1'b0);
        // credit exhaustion on a 6-flit packet
        do_reset();
        q[1] = '{8'h41, 8'h01, 8'h02, 8'h03, 8'h04, 8'h85};
        repeat (6) step(4'b0010, 1'b0);
        step(4'b0010, 1'b1);
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b1);
        step(4'b0010, 1'b1);
        step(4'b0010, 1'b0);
        // credit overflow is sticky and does not raise the count
        do_reset();
        step(4'h0, 1'b1);
        step(4'h0, 1'b0);
        repeat (5) q[0].push_back(8'hC7);
        repeat (6) step(4'h1, 1'b0);
        // reset mid-packet drops the lock
        do_reset();
        q[3] = '{8'h43, 8'h05, 8'h06, 8'h87};
        repeat (2) step(4'b1000, 1'b0);
        do_reset();
        q[0] = '{8'h41, 8'h86}; q[3] = '{8'h42, 8'h86};
        repeat (5) step(4'hF, 1'b0);
        // random traffic
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int v = 0; v < 4; v++)
                if (q[v].size() < 3 && $urandom_range(3) == 0) add_packet(v, $urandom_range(1, 5));
            step(4'($urandom), credits < CREDITS && $urandom_range(1) == 1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
